output_interpolator: RTL and testbench
======================================

Name: output_interpolator

Overview:
- Output-side counterpart of the input oversample filter.
- Takes one PID output word per update (valid pulse) and spreads the move from the current DAC/DDS value to the new target over 2^osm equal steps, one step every step_period+1 clocks.
- Sits between the PID core output and the DAC/DDS instruction path. Limits slew and paces writes so the input filter's settling delay is honoured.

Parameters:
- W_DATA, 16, width of input target and output data (signed).
- W_OSM, 3, width of interpolation mode; MAX_OS = 2^W_OSM - 1 (max 128 steps).
- OSM_INIT, 0, osm value after reset.
- PERIOD_INIT, 0, step_period value after reset.

Ports:
- clk_in, input, 1, system clock.
- reset_in, input, 1, system reset.
- data_in, input, W_DATA, signed target value from PID core.
- data_valid_in, input, 1, one-cycle target strobe; any spacing is allowed.
- step_period_in, input, 16, idle clocks between steps (frontpanel).
- osm_in, input, W_OSM, log2 of step count (frontpanel).
- activate_in, input, 1, channel enable.
- update_en_in, input, 1, sensitizes block to update_in.
- update_in, input, 1, latch pulse for frontpanel parameters.
- data_out, output, W_DATA, signed interpolated value (registered).
- data_valid_out, output, 1, one-cycle pulse per emitted step (registered).
- busy_out, output, 1, high while a ramp is in progress.

Interface (already decided): one clock, clk_in. reset_in is asynchronous and active-high.

Behaviour:
- Reset (async, immediate): data_out=0, data_valid_out=0, busy_out=0, state=IDLE, pending cleared, osm_cur=OSM_INIT, period_cur=PERIOD_INIT.
- Parameter latch: on update_in & update_en_in, osm_cur<=osm_in and period_cur<=step_period_in. Parameters are retained across deactivation.
- Deactivate (activate_in=0): synchronous return to IDLE, pending cleared, data_valid_out=0, busy_out=0. data_out holds its last value so the DAC never jumps.
- Capture: data_valid_in while active writes target into a one-deep pending register, overwriting any older pending value. data_valid_in while inactive is ignored.
- Accumulator: signed, width W_DATA+1+MAX_OS, fixed point with MAX_OS fractional bits. data_out = acc >>> MAX_OS (floor).
- States:
  - IDLE: if pending, go to LOAD and consume pending.
  - LOAD (1 clk):
    - snapshot osm_run=osm_cur and per_run=period_cur;
    - delta = target - data_out, width W_DATA+1;
    - step = (delta <<< MAX_OS) >>> osm_run;
    - acc = data_out <<< MAX_OS;
    - step counter = 0;
    - go to WAIT.
  - WAIT: count per_run clocks; per_run=0 means zero clocks in WAIT. Then go to EMIT.
  - EMIT (1 clk):
    - acc += step; on the final step (counter == 2^osm_run - 1), acc is forced to target<<<MAX_OS so the end value is exact;
    - data_out/data_valid_out are registered on entering EMIT, with data_valid_out=1 for that single cycle;
    - if pending: go to LOAD (retarget from the current data_out);
    - else if final step: go to IDLE;
    - else: counter++ and go to WAIT.
- Latency: data_valid_in at edge t gives the first data_valid_out pulse in cycle t+2+per_run (IDLE→LOAD→WAIT→EMIT). Subsequent pulses are spaced per_run+1 clocks apart.
- A retarget takes effect only at a step boundary. The current step is always emitted before the retarget.
- osm_run=0: exactly one step, and data_out = target.
- target == data_out: still emits 2^osm_run pulses, all at the unchanged value.
- No saturation is needed: intermediate values always lie between the start and target values.
- busy_out = (state != IDLE).
- Parameter updates during a ramp affect only the next LOAD.

Test Plan:
- osm=2, period=3, data_out=0, target 100 → pulses with 25, 50, 75, 100; first pulse 5 clks after strobe, then every 4 clks; busy_out drops after the 100 pulse.
- osm=1, period=0, from 100, target -3 → outputs 48 then -3, on consecutive EMITs 1 clk apart (period+1).
- osm=2, period=2, 0→400, with a new target 0 strobed after the first pulse (100) → remaining outputs 75, 50, 25, 0; no 200 is emitted; the last value is exactly 0.
- osm=3 ramp in progress, activate_in deasserted → data_valid_out stops next cycle, data_out frozen, busy_out=0; a strobe while inactive produces no output after reactivation.
- reset_in asserted mid-ramp, asynchronously between edges → data_out=0, data_valid_out=0, busy_out=0 immediately; parameters return to OSM_INIT/PERIOD_INIT.
- update_in with update_en_in=0 → parameters unchanged. update_in with update_en_in=1 mid-ramp → the current ramp keeps its old step count and spacing; the next ramp uses the new values.

Source files
------------

// File: rtl/output_interpolator.sv
// Output interpolator: ramps data_out from its present value to each new target in 2^osm equal
// steps, emitting one step every step_period+1 clocks, so DAC/DDS writes are slew-limited and
// paced.
module output_interpolator #(
   parameter int unsigned W_DATA      = 16,
   parameter int unsigned W_OSM       = 3,
   parameter int unsigned OSM_INIT    = 0,
   parameter int unsigned PERIOD_INIT = 0
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic signed [W_DATA-1:0] data_in,
   input  logic                     data_valid_in,
   input  logic        [15:0]       step_period_in,
   input  logic        [W_OSM-1:0]  osm_in,
   input  logic                     activate_in,
   input  logic                     update_en_in,
   input  logic                     update_in,
   output logic signed [W_DATA-1:0] data_out,
   output logic                     data_valid_out,
   output logic                     busy_out
);

   localparam int unsigned MAX_OS = (1 << W_OSM) - 1;
   localparam int unsigned W_ACC  = W_DATA + 1 + MAX_OS;
   localparam int unsigned W_CNT  = MAX_OS;  // step index 0 .. 2^MAX_OS-1

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StEmit} state_t;

   state_t                    state_q, state_d;
   logic                      pending_q, pending_d;
   logic signed [W_DATA-1:0]  pend_data_q, pend_data_d;
   logic signed [W_DATA-1:0]  target_q, target_d;
   logic        [W_OSM-1:0]   osm_cur_q, osm_cur_d;
   logic        [15:0]        period_cur_q, period_cur_d;
   logic        [W_OSM-1:0]   osm_run_q, osm_run_d;
   logic        [15:0]        per_run_q, per_run_d;
   logic signed [W_ACC-1:0]   step_q, step_d;
   logic signed [W_ACC-1:0]   acc_q, acc_d;
   logic        [W_CNT-1:0]   cnt_q, cnt_d;
   logic        [15:0]        wait_q, wait_d;
   logic signed [W_DATA-1:0]  out_q, out_d;
   logic                      valid_q, valid_d;

   // Working values for the step being emitted on this edge
   logic signed [W_DATA:0]    delta;
   logic signed [W_ACC-1:0]   ld_step, ld_acc, tgt_acc;
   logic signed [W_ACC-1:0]   em_acc, em_step, em_acc_next;
   logic        [W_CNT-1:0]   em_cnt;
   logic        [W_OSM-1:0]   em_osm;
   logic                      em_final, cur_final, emit, consume;

   // Index of the last step for a given osm: 2^osm - 1
   function automatic logic [W_CNT-1:0] last_idx(input logic [W_OSM-1:0] osm);
      logic [W_CNT:0] span;
      span = {{W_CNT{1'b0}}, 1'b1} << osm;
      return W_CNT'(span - {{W_CNT{1'b0}}, 1'b1});
   endfunction

   // Frontpanel parameter latch; values survive deactivation
   always_comb begin
      osm_cur_d    = osm_cur_q;
      period_cur_d = period_cur_q;
      if (update_in && update_en_in) begin
         osm_cur_d    = osm_in;
         period_cur_d = step_period_in;
      end
   end

   // Ramp setup values and the accumulator step selected by the current state
   always_comb begin
      delta   = {target_q[W_DATA-1], target_q} - {out_q[W_DATA-1], out_q};
      ld_step = $signed({delta, {MAX_OS{1'b0}}}) >>> osm_cur_q;
      ld_acc  = {out_q[W_DATA-1], out_q, {MAX_OS{1'b0}}};
      tgt_acc = {target_q[W_DATA-1], target_q, {MAX_OS{1'b0}}};
      em_acc  = acc_q;
      em_step = step_q;
      em_cnt  = cnt_q;
      em_osm  = osm_run_q;
      unique case (state_q)
         StLoad: begin
            // First step emitted straight out of LOAD when the period is zero
            em_acc  = ld_acc;
            em_step = ld_step;
            em_cnt  = '0;
            em_osm  = osm_cur_q;
         end
         StEmit: em_cnt = cnt_q + W_CNT'(1);
         default: ;
      endcase
      em_final    = (em_cnt == last_idx(em_osm));
      // Final step lands exactly on the target regardless of rounding
      em_acc_next = em_final ? tgt_acc : em_acc + em_step;
      cur_final   = (cnt_q == last_idx(osm_run_q));
   end

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      pend_data_d = pend_data_q;
      target_d    = target_q;
      osm_run_d   = osm_run_q;
      per_run_d   = per_run_q;
      step_d      = step_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      out_d       = out_q;
      valid_d     = 1'b0;
      emit        = 1'b0;
      consume     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pending_q) begin
               consume = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            osm_run_d = osm_cur_q;
            per_run_d = period_cur_q;
            step_d    = ld_step;
            acc_d     = ld_acc;
            cnt_d     = '0;
            if (period_cur_q == 16'd0) begin
               emit    = 1'b1;
               state_d = StEmit;
            end else begin
               wait_d  = period_cur_q - 16'd1;
               state_d = StWait;
            end
         end
         StWait: begin
            if (wait_q == 16'd0) begin
               emit    = 1'b1;
               state_d = StEmit;
            end else begin
               wait_d = wait_q - 16'd1;
            end
         end
         StEmit: begin
            if (pending_q) begin
               // Retarget from the value just emitted
               consume = 1'b1;
               state_d = StLoad;
            end else if (cur_final) begin
               state_d = StIdle;
            end else if (per_run_q == 16'd0) begin
               emit    = 1'b1;
               state_d = StEmit;
            end else begin
               cnt_d   = cnt_q + W_CNT'(1);
               wait_d  = per_run_q - 16'd1;
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase

      if (emit) begin
         acc_d   = em_acc_next;
         cnt_d   = em_cnt;
         out_d   = em_acc_next[MAX_OS +: W_DATA];
         valid_d = 1'b1;
      end

      if (consume) begin
         pending_d = 1'b0;
         target_d  = pend_data_q;
      end

      // Capture after consume so a strobe in the consuming cycle stays pending
      if (activate_in && data_valid_in) begin
         pending_d   = 1'b1;
         pend_data_d = data_in;
      end

      // Deactivation parks the channel but keeps data_out so the DAC never jumps
      if (!activate_in) begin
         state_d   = StIdle;
         pending_d = 1'b0;
         valid_d   = 1'b0;
         out_d     = out_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= StIdle;
         pending_q    <= 1'b0;
         pend_data_q  <= '0;
         target_q     <= '0;
         osm_cur_q    <= W_OSM'(OSM_INIT);
         period_cur_q <= 16'(PERIOD_INIT);
         osm_run_q    <= '0;
         per_run_q    <= '0;
         step_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         wait_q       <= '0;
         out_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         pend_data_q  <= pend_data_d;
         target_q     <= target_d;
         osm_cur_q    <= osm_cur_d;
         period_cur_q <= period_cur_d;
         osm_run_q    <= osm_run_d;
         per_run_q    <= per_run_d;
         step_q       <= step_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         wait_q       <= wait_d;
         out_q        <= out_d;
         valid_q      <= valid_d;
      end
   end

   assign data_out       = out_q;
   assign data_valid_out = valid_q;
   assign busy_out       = (state_q != StIdle);

endmodule

// File: tb/tb_output_interpolator.sv
// Bench for output_interpolator: directed scenarios plus randomized ramps, each checked against a
// transaction-level model of the pulse values and their cycle numbers.
module tb_output_interpolator;

   logic               clk_in = 1'b0;
   logic               reset_in;
   logic signed [15:0] data_in;
   logic               data_valid_in;
   logic        [15:0] step_period_in;
   logic        [2:0]  osm_in;
   logic               activate_in;
   logic               update_en_in;
   logic               update_in;
   logic signed [15:0] data_out;
   logic               data_valid_out;
   logic               busy_out;

   int     n_cmp  = 0;
   int     n_fail = 0;
   longint cyc    = 0;
   longint cur    = 0;            // value data_out should hold when idle
   longint pv[$], pt[$];          // observed pulse values / cycles
   longint ev[$], et[$];          // expected pulse values / cycles

   output_interpolator dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .data_in        (data_in),
      .data_valid_in  (data_valid_in),
      .step_period_in (step_period_in),
      .osm_in         (osm_in),
      .activate_in    (activate_in),
      .update_en_in   (update_en_in),
      .update_in      (update_in),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .busy_out       (busy_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Pulses are recorded on the falling edge, with the number of the rising edge that made them
   always @(negedge clk_in) begin
      if (data_valid_out === 1'b1) begin
         pv.push_back(longint'(data_out));
         pt.push_back(cyc);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run still going at time %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   // Ramp model: step k (0-based) of 2^osm lands on start + floor((k+1)*(target-start)/2^osm)
   // at edge ts + 2 + per + k*(per+1), where ts is the edge that sampled the strobe.
   task automatic model_ramp(input longint start, input longint target, input int osm,
                             input int per, input longint ts, input int max_pulses);
      longint n = longint'(1) << osm;
      for (longint k = 0; k < n && k < max_pulses; k++) begin
         ev.push_back(start + (((k + 1) * (target - start)) >>> osm));
         et.push_back(ts + 2 + per + k * (per + 1));
      end
   endtask

   task automatic clear_q();
      pv.delete(); pt.delete(); ev.delete(); et.delete();
   endtask

   task automatic set_params(input int osm, input int per, input bit en);
      @(negedge clk_in);
      osm_in         = 3'(osm);
      step_period_in = 16'(per);
      update_en_in   = en;
      update_in      = 1'b1;
      @(negedge clk_in);
      update_in    = 1'b0;
      update_en_in = 1'b0;
   endtask

   task automatic strobe(input longint v, output longint ts);
      @(negedge clk_in);
      data_in       = 16'(v);
      data_valid_in = 1'b1;
      ts            = cyc + 1;
      @(negedge clk_in);
      data_valid_in = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      repeat (2) @(negedge clk_in);
      for (int i = 0; i < 3000; i++) begin
         if (busy_out === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_in);
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (data_out !== 16'sd0) begin
         n_fail++; $display("FAIL reset data_out: got %0d want 0", data_out);
      end
      n_cmp++;
      if (data_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL reset data_valid_out: got %b want 0", data_valid_out);
      end
      n_cmp++;
      if (busy_out !== 1'b0) begin
         n_fail++; $display("FAIL reset busy_out: got %b want 0", busy_out);
      end
      repeat (2) @(negedge clk_in);
      reset_in = 1'b0;
   endtask

   task automatic test_basic();
      longint ts;
      clear_q();
      set_params(2, 3, 1'b1);
      strobe(100, ts);
      model_ramp(cur, 100, 2, 3, ts, 1000);
      while (cyc < et[et.size() - 1]) @(negedge clk_in);
      n_cmp++;
      if (busy_out !== 1'b1) begin
         n_fail++; $display("FAIL basic busy at last pulse: got %b want 1", busy_out);
      end
      @(negedge clk_in);
      n_cmp++;
      if (busy_out !== 1'b0) begin
         n_fail++; $display("FAIL basic busy after last pulse: got %b want 0", busy_out);
      end
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL basic count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL basic pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = 100;
   endtask

   task automatic test_negative();
      longint ts;
      bit ok;
      clear_q();
      set_params(1, 0, 1'b1);
      strobe(-3, ts);
      model_ramp(cur, -3, 1, 0, ts, 1000);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL negative idle: busy %b after budget want 0", busy_out);
      end
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL negative count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL negative pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = -3;
   endtask

   // New target strobed so it is pending when the first step is emitted
   task automatic test_retarget();
      longint ts;
      bit ok;
      set_params(0, 0, 1'b1);
      strobe(0, ts);
      wait_idle(ok);
      cur = 0;
      clear_q();
      set_params(2, 2, 1'b1);
      strobe(400, ts);
      while (cyc < ts + 3) @(negedge clk_in);
      data_in       = 16'sd0;
      data_valid_in = 1'b1;
      @(negedge clk_in);
      data_valid_in = 1'b0;
      model_ramp(cur, 400, 2, 2, ts, 1);
      model_ramp(ev[0], 0, 2, 2, ts + 4, 1000);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL retarget idle: busy %b after budget want 0", busy_out);
      end
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL retarget count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL retarget pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = 0;
   endtask

   // Two strobes on consecutive edges: first starts a ramp, second retargets at its first step
   task automatic test_back_to_back();
      longint ts;
      bit ok;
      clear_q();
      set_params(2, 1, 1'b1);
      @(negedge clk_in);
      data_in       = 16'sd1000;
      data_valid_in = 1'b1;
      ts            = cyc + 1;
      @(negedge clk_in);
      data_in       = -16'sd600;
      @(negedge clk_in);
      data_valid_in = 1'b0;
      model_ramp(cur, 1000, 2, 1, ts, 1);
      model_ramp(ev[0], -600, 2, 1, ts + 3, 1000);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL b2b idle: busy %b after budget want 0", busy_out);
      end
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL b2b count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL b2b pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = -600;
   endtask

   task automatic test_deactivate();
      longint ts;
      longint frozen;
      set_params(0, 0, 1'b1);
      strobe(0, ts);
      repeat (4) @(negedge clk_in);
      cur = 0;
      clear_q();
      set_params(3, 1, 1'b1);
      strobe(800, ts);
      model_ramp(cur, 800, 3, 1, ts, 2);
      frozen = ev[1];
      while (cyc < et[1]) @(negedge clk_in);
      activate_in = 1'b0;
      @(negedge clk_in);
      n_cmp++;
      if (data_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL deact valid: got %b want 0", data_valid_out);
      end
      n_cmp++;
      if (busy_out !== 1'b0) begin
         n_fail++; $display("FAIL deact busy: got %b want 0", busy_out);
      end
      strobe(-1000, ts);
      repeat (2) @(negedge clk_in);
      activate_in = 1'b1;
      repeat (20) @(negedge clk_in);
      n_cmp++;
      if (longint'(data_out) !== frozen) begin
         n_fail++; $display("FAIL deact frozen data_out: got %0d want %0d", data_out, frozen);
      end
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL deact count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL deact pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = frozen;
   endtask

   task automatic test_update();
      longint ts, ts2;
      bit ok;
      clear_q();
      set_params(1, 1, 1'b1);
      set_params(3, 5, 1'b0);        // not enabled: must be ignored
      strobe(1000, ts);
      model_ramp(cur, 1000, 1, 1, ts, 1000);
      @(negedge clk_in);
      set_params(2, 0, 1'b1);        // mid-ramp: only the next ramp sees it
      wait_idle(ok);
      strobe(40, ts2);
      model_ramp(1000, 40, 2, 0, ts2, 1000);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin
         n_fail++; $display("FAIL update idle: busy %b after budget want 0", busy_out);
      end
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL update count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL update pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = 40;
   endtask

   task automatic test_async_reset();
      longint ts;
      bit ok;
      set_params(3, 2, 1'b1);
      strobe(-2000, ts);
      while (cyc < ts + 6) @(negedge clk_in);
      @(posedge clk_in);
      #2;
      reset_in = 1'b1;
      #1;
      n_cmp++;
      if (data_out !== 16'sd0) begin
         n_fail++; $display("FAIL areset data_out: got %0d want 0", data_out);
      end
      n_cmp++;
      if (data_valid_out !== 1'b0) begin
         n_fail++; $display("FAIL areset valid: got %b want 0", data_valid_out);
      end
      n_cmp++;
      if (busy_out !== 1'b0) begin
         n_fail++; $display("FAIL areset busy: got %b want 0", busy_out);
      end
      @(negedge clk_in);
      reset_in = 1'b0;
      clear_q();
      // Parameters are back to osm=0, period=0: one step, two edges after the strobe
      strobe(77, ts);
      model_ramp(0, 77, 0, 0, ts, 1000);
      wait_idle(ok);
      n_cmp++;
      if (pv.size() != ev.size()) begin
         n_fail++; $display("FAIL areset count: got %0d want %0d", pv.size(), ev.size());
      end
      for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
         n_cmp++;
         if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
            n_fail++;
            $display("FAIL areset pulse %0d: got %0d at %0d want %0d at %0d",
                     i, pv[i], pt[i], ev[i], et[i]);
         end
      end
      cur = 77;
   endtask

   task automatic test_random();
      longint ts, tgt;
      logic signed [15:0] r;
      int osm, per;
      bit ok;
      for (int it = 0; it < 24; it++) begin
         osm = int'($urandom_range(0, 7));
         per = int'($urandom_range(0, 3));
         r   = 16'($urandom);
         tgt = ($urandom_range(0, 4) == 0) ? cur : longint'(r);
         clear_q();
         set_params(osm, per, 1'b1);
         strobe(tgt, ts);
         model_ramp(cur, tgt, osm, per, ts, 1000);
         wait_idle(ok);
         n_cmp++;
         if (!ok) begin
            n_fail++; $display("FAIL random %0d idle: busy %b after budget want 0", it, busy_out);
         end
         n_cmp++;
         if (pv.size() != ev.size()) begin
            n_fail++;
            $display("FAIL random %0d count: got %0d want %0d (osm %0d per %0d)",
                     it, pv.size(), ev.size(), osm, per);
         end
         for (int i = 0; i < ev.size() && i < pv.size(); i++) begin
            n_cmp++;
            if (pv[i] !== ev[i] || pt[i] !== et[i]) begin
               n_fail++;
               $display("FAIL random %0d pulse %0d: got %0d at %0d want %0d at %0d",
                        it, i, pv[i], pt[i], ev[i], et[i]);
            end
         end
         cur = tgt;
      end
   endtask

   initial begin
      reset_in       = 1'b1;
      data_in        = '0;
      data_valid_in  = 1'b0;
      step_period_in = '0;
      osm_in         = '0;
      activate_in    = 1'b1;
      update_en_in   = 1'b0;
      update_in      = 1'b0;
      test_reset();
      test_basic();
      test_negative();
      test_retarget();
      test_back_to_back();
      test_deactivate();
      test_update();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
